// File: rtl/accel_req_buffer.sv
// Request buffer between the vector dispatcher and Ara, with a drain handshake.
// Optional performance counters are enabled with ACCEL_REQ_BUFFER_PERF_CNT_EN.
module accel_req_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_insn_i,
    input  logic [XLEN-1:0] in_rs1_i,
    input  logic [XLEN-1:0] in_rs2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_insn_o,
    output logic [XLEN-1:0] out_rs1_o,
    output logic [XLEN-1:0] out_rs2_o,
    input  logic            drain_i,
    output logic            drained_o,
    output logic            empty_o,
    output logic [63:0]     issued_cnt_o,
    output logic [63:0]     stall_cnt_o
);

    localparam int unsigned PtrWidth = $clog2(DEPTH);
    localparam logic [PtrWidth-1:0] PtrOne   = 1;
    localparam logic [PtrWidth:0]   CntOne   = 1;
    localparam logic [PtrWidth:0]   DepthCnt = DEPTH[PtrWidth:0];

    typedef enum logic {Run, Drain} state_e;

    state_e              state_q, state_d;
    logic                drain_done_q, drain_done_d;
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]   count_q, count_d;
    logic                push, pop;

    logic [31:0]     insn_mem [DEPTH];
    logic [XLEN-1:0] rs1_mem  [DEPTH];
    logic [XLEN-1:0] rs2_mem  [DEPTH];

    assign in_ready_o  = (state_q == Run) && (count_q < DepthCnt);
    assign out_valid_o = (count_q != '0);
    assign empty_o     = (count_q == '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    assign out_insn_o = insn_mem[rd_ptr_q];
    assign out_rs1_o  = rs1_mem[rd_ptr_q];
    assign out_rs2_o  = rs2_mem[rd_ptr_q];

    // Payload storage is deliberately left out of reset; count gates validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            insn_mem[wr_ptr_q] <= in_insn_i;
            rs1_mem[wr_ptr_q]  <= in_rs1_i;
            rs2_mem[wr_ptr_q]  <= in_rs2_i;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        drained_o    = 1'b0;
        unique case (state_q)
            Run: begin
                if (drain_i) state_d = Drain;
            end
            Drain: begin
                // Pulse only on the first empty cycle of this drain visit.
                drained_o    = (count_q == '0) && !drain_done_q;
                drain_done_d = drain_done_q | drained_o;
                if ((count_q == '0) && !drain_i) begin
                    state_d      = Run;
                    drain_done_d = 1'b0;
                end
            end
            default: state_d = Run;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= Run;
            drain_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
            count_q      <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

`ifdef ACCEL_REQ_BUFFER_PERF_CNT_EN
    logic [63:0] issued_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (pop)                        issued_cnt_q <= issued_cnt_q + 64'd1;
            if (out_valid_o && !out_ready_i) stall_cnt_q  <= stall_cnt_q + 64'd1;
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`else
    assign issued_cnt_o = '0;
    assign stall_cnt_o  = '0;
`endif

endmodule
